// File: rtl/renode_axi_subordinate_mem.sv
// ---------------------------------------------------------------------------
// renode_axi_subordinate_mem
//
// AXI4 subordinate backed by a word-addressed on-chip memory. Serves
// Renode-initiated reads and writes and acts as the default memory model in
// co-simulation benches. Single-beat, FIXED and INCR bursts are supported.
// Errors are decided once per burst, when the address is accepted, and are
// reported as SLVERR for the whole burst.
//
// Ports
//   clk, areset_n            : bus clock (posedge), async active-low reset
//   aw*  / awvalid / awready : write address channel
//   wdata/wstrb/wlast/wvalid/wready : write data channel
//   bid/bresp/bvalid/bready  : write response channel
//   ar*  / arvalid / arready : read address channel
//   rid/rdata/rresp/rlast/rvalid/rready : read data channel
//
// The read and write paths are independent state machines and may run
// concurrently. The read path fetches one beat every two cycles.
// ---------------------------------------------------------------------------
module renode_axi_subordinate_mem #(
  parameter int AddressWidth       = 20,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8,
  parameter int MemoryDepth        = 1024
) (
  input  logic                          clk,
  input  logic                          areset_n,
  // write address
  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  // write data
  input  logic [DataWidth-1:0]          wdata,
  input  logic [DataWidth/8-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  // write response
  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  // read address
  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  // read data
  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int StrobeWidth = DataWidth / 8;
  localparam int ByteOffW    = $clog2(StrobeWidth);
  localparam int IdxW        = $clog2(MemoryDepth);
  // Wide enough to hold start + 255 beats of the largest legal size without
  // wrapping, so out-of-range bursts are never mistaken for in-range ones.
  localparam int ExtW        = AddressWidth + 16;
  localparam logic [ExtW-1:0] MemBytes = ExtW'(MemoryDepth * StrobeWidth);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Address of the following beat. INCR aligns down to the transfer size
  // before stepping, so an unaligned start only affects the first beat.
  function automatic logic [AddressWidth-1:0] next_addr(
    input logic [AddressWidth-1:0] addr,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic [AddressWidth-1:0] step;
    step = AddressWidth'(1) << size;
    if (burst == BurstFixed) next_addr = addr;
    else                     next_addr = (addr & ~(step - AddressWidth'(1))) + step;
  endfunction

  // Whole-burst error check. The highest beat address of an INCR burst is
  // the aligned start plus len steps; a FIXED burst only touches its start.
  function automatic logic burst_err(
    input logic [AddressWidth-1:0] addr,
    input logic [7:0]              len,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic [ExtW-1:0] start_a;
    logic [ExtW-1:0] last_a;
    logic [ExtW-1:0] mask;
    start_a = ExtW'(addr);
    mask    = (ExtW'(1) << size) - ExtW'(1);
    if (burst == BurstFixed || len == 8'd0) last_a = start_a;
    else last_a = (start_a & ~mask) + (ExtW'(len) << size);
    burst_err = (burst != BurstFixed && burst != BurstIncr) ||
                (size > 3'(ByteOffW)) ||
                (last_a >= MemBytes);
  endfunction

  // Lock and protection attributes carry no meaning for a plain memory.
  logic unused_sideband;
  assign unused_sideband = ^{awlock, awprot, arlock, arprot};

  logic [DataWidth-1:0] mem [MemoryDepth];

  // ------------------------------------------------------------------
  // Write path
  // ------------------------------------------------------------------
  w_state_t                    w_state;
  logic [7:0]                  w_cnt;
  logic [AddressWidth-1:0]     w_addr;
  logic [2:0]                  w_size;
  logic [1:0]                  w_burst;
  logic [TransactionIdWidth-1:0] w_id;
  logic                        w_err;
  logic                        w_last_err;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        b_hs;
  logic                        w_final;
  logic                        mem_we;
  logic [IdxW-1:0]             w_idx;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;
  assign w_final = (w_cnt == 8'd0);
  assign mem_we  = w_hs & ~w_err;
  assign w_idx   = w_addr[ByteOffW +: IdxW];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RespOkay;
      w_cnt   <= 8'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_cnt   <= awlen;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_final) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              // A missing wlast on the final beat is as wrong as an early one.
              bresp   <= (w_err || w_last_err || !wlast) ? RespSlverr : RespOkay;
              w_state <= W_RESP;
            end else begin
              w_cnt <= w_cnt - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Burst context is only meaningful between AW and B, so it needs no reset.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_addr     <= awaddr;
      w_size     <= awsize;
      w_burst    <= awburst;
      w_id       <= awid;
      w_err      <= burst_err(awaddr, awlen, awsize, awburst);
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      if (wlast && !w_final) w_last_err <= 1'b1;
    end
  end

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < StrobeWidth; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  r_state_t                    r_state;
  logic [7:0]                  r_cnt;
  logic [AddressWidth-1:0]     r_addr;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic [TransactionIdWidth-1:0] r_id;
  logic                        r_err;
  logic                        ar_hs;
  logic                        r_hs;
  logic [IdxW-1:0]             r_idx;

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign r_idx = r_addr[ByteOffW +: IdxW];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RespOkay;
      rdata   <= '0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            r_cnt   <= arlen;
            r_state <= R_FETCH;
          end else begin
            arready <= 1'b1;
          end
        end
        R_FETCH: begin
          // Nonblocking read: a write to the same word on this edge is not
          // visible yet, so the beat carries the pre-write contents.
          rvalid  <= 1'b1;
          rlast   <= (r_cnt == 8'd0);
          rid     <= r_id;
          rresp   <= r_err ? RespSlverr : RespOkay;
          rdata   <= r_err ? '0 : mem[r_idx];
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_addr  <= araddr;
      r_size  <= arsize;
      r_burst <= arburst;
      r_id    <= arid;
      r_err   <= burst_err(araddr, arlen, arsize, arburst);
    end else if (r_hs) begin
      r_addr <= next_addr(r_addr, r_size, r_burst);
    end
  end

endmodule

// File: tb/tb_renode_axi_subordinate_mem.sv
module tb_renode_axi_subordinate_mem;

  logic        clk = 1'b0;
  logic        areset_n;
  logic [7:0]  awid;   logic [19:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awlock; logic [2:0] awprot; logic awvalid; logic awready;
  logic [31:0] wdata;  logic [3:0] wstrb; logic wlast; logic wvalid; logic wready;
  logic [7:0]  bid;    logic [1:0] bresp; logic bvalid; logic bready;
  logic [7:0]  arid;   logic [19:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arlock; logic [2:0] arprot; logic arvalid; logic arready;
  logic [7:0]  rid;    logic [31:0] rdata; logic [1:0] rresp; logic rlast; logic rvalid; logic rready;

  int errors;
  int checks;

  // reference memory and per-burst beat buffers
  logic [31:0] mem_m [1024];
  logic [31:0] bd [256];
  logic [3:0]  bs [256];
  logic [31:0] ed [256];
  logic [1:0]  er [256];
  logic [31:0] rd [256];
  logic [1:0]  rr [256];
  logic        rl [256];
  logic [7:0]  ri [256];

  always #5 clk = ~clk;

  renode_axi_subordinate_mem dut (
    .clk(clk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want < 500000", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Address of beat k: FIXED repeats the start, INCR steps from the aligned start.
  function automatic int beat_addr(input int addr, input int size, input int burst, input int k);
    int step;
    step = 1 << size;
    if (burst == 0 || k == 0) return addr;
    return (addr / step) * step + k * step;
  endfunction

  function automatic bit m_err(input int addr, input int len, input int size, input int burst);
    if (burst > 1 || size > 2) return 1'b1;
    for (int k = 0; k <= len; k++)
      if (beat_addr(addr, size, burst, k) >= 4096) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_write(input int addr, input int len, input int size,
                                             input int burst, input bit bad_last);
    bit e;
    int a;
    e = m_err(addr, len, size, burst);
    if (!e)
      for (int k = 0; k <= len; k++) begin
        a = beat_addr(addr, size, burst, k);
        for (int b = 0; b < 4; b++)
          if (bs[k][b]) mem_m[a/4][b*8 +: 8] = bd[k][b*8 +: 8];
      end
    return (e || bad_last) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_read(input int addr, input int len, input int size, input int burst);
    bit e;
    e = m_err(addr, len, size, burst);
    for (int k = 0; k <= len; k++) begin
      ed[k] = e ? 32'h0 : mem_m[beat_addr(addr, size, burst, k) / 4];
      er[k] = e ? 2'b10 : 2'b00;
    end
  endfunction

  // ---------------- bus drivers ----------------
  task automatic aw_send(input logic [7:0] id, input int addr, input int len, input int size, input int burst);
    bit ok;
    awid = id; awaddr = 20'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 awvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL aw_timeout: awready got 0 for 50 cycles, want 1"); end
  endtask

  task automatic ar_send(input logic [7:0] id, input int addr, input int len, input int size, input int burst);
    bit ok;
    arid = id; araddr = 20'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 arvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ar_timeout: arready got 0 for 50 cycles, want 1"); end
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic lst, input bit thr);
    bit ok;
    if (thr) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wlast = lst; wvalid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 wvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL w_timeout: wready got 0 for 50 cycles, want 1"); end
  endtask

  task automatic b_recv(input bit thr, output logic [7:0] id_o, output logic [1:0] resp_o, output int wait_n);
    bit seen, done;
    logic [9:0] prev;
    seen = 0; done = 0; wait_n = 0; id_o = 'x; resp_o = 'x; prev = '0;
    bready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (bvalid) begin
        if (seen) begin
          checks++;
          if ({bid, bresp} !== prev) begin
            errors++; $display("FAIL b_stable: got id/resp %h, want %h held", {bid, bresp}, prev);
          end
        end
        prev = {bid, bresp}; seen = 1;
        if (bready) begin id_o = bid; resp_o = bresp; done = 1; end
      end else if (seen) begin
        checks++; errors++; $display("FAIL b_dropped: bvalid got 0 before handshake, want 1");
      end else wait_n++;
      if (!done) begin @(posedge clk); #1 bready = (thr && c < 8) ? 1'($urandom_range(0, 1)) : 1'b1; end
    end
    @(posedge clk); #1 bready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL b_timeout: bvalid handshake got none in 60 cycles, want 1"); end
  endtask

  task automatic do_write(input logic [7:0] id, input int addr, input int len, input int size,
                          input int burst, input bit wthr, input bit bthr, input int bad,
                          output logic [7:0] id_o, output logic [1:0] resp_o, output int wait_n);
    aw_send(id, addr, len, size, burst);
    for (int k = 0; k <= len; k++)
      w_send(bd[k], bs[k], (k == len) ^ (k == bad), wthr);
    b_recv(bthr, id_o, resp_o, wait_n);
  endtask

  // Collects len+1 beats into rd/rr/rl/ri; checks 2-cycle beat spacing and payload hold.
  task automatic do_read(input logic [7:0] id, input int addr, input int len, input int size,
                         input int burst, input bit thr);
    bit seen, got;
    int lat;
    logic [42:0] prev;
    ar_send(id, addr, len, size, burst);
    rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k <= len; k++) begin
      seen = 0; got = 0; lat = 0; prev = '0;
      rd[k] = 'x; rr[k] = 'x; rl[k] = 'x; ri[k] = 'x;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk); lat++;
        if (rvalid) begin
          checks++;
          if (!seen && lat != 2) begin
            errors++; $display("FAIL r_latency beat %0d: got rvalid after %0d cycles, want 2", k, lat);
          end else if (seen && {rdata, rresp, rlast, rid} !== prev) begin
            errors++; $display("FAIL r_stable beat %0d: got %h, want %h held", k, {rdata, rresp, rlast, rid}, prev);
          end
          prev = {rdata, rresp, rlast, rid}; seen = 1;
          if (rready) begin rd[k] = rdata; rr[k] = rresp; rl[k] = rlast; ri[k] = rid; got = 1; end
        end else if (seen) begin
          checks++; errors++; $display("FAIL r_dropped beat %0d: rvalid got 0 before handshake, want 1", k);
        end
        if (!got) begin @(posedge clk); #1 rready = (thr && c < 8) ? 1'($urandom_range(0, 1)) : 1'b1; end
      end
      if (!got) begin
        checks++; errors++; $display("FAIL r_timeout beat %0d: got no handshake in 40 cycles, want 1", k);
      end
      @(posedge clk); #1 rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset_n = 1'b0; awvalid = 1'b1; awid = 8'h0; awaddr = '0; awlen = '0; awsize = 3'd2;
    awburst = 2'b01; awlock = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    arlock = 0; arprot = 0; rready = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, want 000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    checks++;
    if ({bid, bresp, rid, rresp, rdata} !== 52'b0) begin
      errors++; $display("FAIL reset_payload: got %h, want 0", {bid, bresp, rid, rresp, rdata});
    end
    @(negedge clk) areset_n = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b0) begin errors++; $display("FAIL awready_pre_edge: got %b, want 0", awready); end
    @(posedge clk); #1 awvalid = 1'b0;
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release: got %b, want 11", {awready, arready});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wready, bvalid} !== 2'b00) begin
      errors++; $display("FAIL no_spurious_aw: got wready/bvalid %b, want 00", {wready, bvalid});
    end
  endtask

  task automatic fill_memory();
    logic [7:0] id_o; logic [1:0] resp_o, want; int wn;
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
      do_write(8'(blk), blk * 1024, 255, 2, 1, 0, 0, -1, id_o, resp_o, wn);
      want = model_write(blk * 1024, 255, 2, 1, 0);
      checks++;
      if (resp_o !== want) begin errors++; $display("FAIL fill_bresp blk %0d: got %0d, want %0d", blk, resp_o, want); end
    end
  endtask

  task automatic test_single();
    logic [7:0] id_o; logic [1:0] resp_o, want; int wn;
    bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
    do_write(8'd3, 'h10, 0, 2, 1, 0, 0, -1, id_o, resp_o, wn);
    want = model_write('h10, 0, 2, 1, 0);
    checks++;
    if (id_o !== 8'd3 || resp_o !== 2'b00 || resp_o !== want) begin
      errors++; $display("FAIL single_b: got bid=%0d bresp=%0d, want bid=3 bresp=0", id_o, resp_o);
    end
    checks++;
    if (wn !== 0) begin errors++; $display("FAIL single_b_latency: got %0d idle cycles, want 0", wn); end
    do_read(8'd5, 'h10, 0, 2, 1, 0);
    checks++;
    if (rd[0] !== 32'hDEADBEEF || rr[0] !== 2'b00 || rl[0] !== 1'b1 || ri[0] !== 8'd5) begin
      errors++; $display("FAIL single_r: got data=%h resp=%0d last=%b id=%0d, want data=deadbeef resp=0 last=1 id=5",
                         rd[0], rr[0], rl[0], ri[0]);
    end
  endtask

  task automatic test_incr_burst();
    logic [7:0] id_o; logic [1:0] resp_o, want; int wn;
    logic [31:0] old1;
    old1 = mem_m['h104 / 4];
    for (int k = 0; k < 4; k++) begin bd[k] = 32'(k + 1); bs[k] = 4'hF; end
    bs[1] = 4'h3;
    do_write(8'd9, 'h100, 3, 2, 1, 1, 1, -1, id_o, resp_o, wn);
    want = model_write('h100, 3, 2, 1, 0);
    checks++;
    if (id_o !== 8'd9 || resp_o !== want) begin
      errors++; $display("FAIL incr_b: got bid=%0d bresp=%0d, want bid=9 bresp=%0d", id_o, resp_o, want);
    end
    model_read('h100, 3, 2, 1);
    checks++;
    if (ed[1] !== {old1[31:16], 16'h0002}) begin
      errors++; $display("FAIL incr_model_beat2: got %h, want %h", ed[1], {old1[31:16], 16'h0002});
    end
    do_read(8'd10, 'h100, 3, 2, 1, 0);
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (rd[k] !== ed[k] || rr[k] !== er[k] || rl[k] !== (k == 3) || ri[k] !== 8'd10) begin
        errors++; $display("FAIL incr_r beat %0d: got data=%h resp=%0d last=%b id=%0d, want data=%h resp=%0d last=%b id=10",
                           k, rd[k], rr[k], rl[k], ri[k], ed[k], er[k], k == 3);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] id_o; logic [1:0] resp_o; int wn;
    int wa[3]; int wl[3]; int ws[3]; int ra[3]; int rln[3];
    wa = '{4096, 'h30, 'hFF8}; wl = '{0, 0, 3}; ws = '{2, 3, 2};
    ra = '{0, 'h30, 'hFF8};   rln = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k <= wl[t]; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
      do_write(8'(20 + t), wa[t], wl[t], ws[t], 1, 1, 1, -1, id_o, resp_o, wn);
      void'(model_write(wa[t], wl[t], ws[t], 1, 0));
      checks++;
      if (resp_o !== 2'b10 || id_o !== 8'(20 + t)) begin
        errors++; $display("FAIL err_write %0d: got bresp=%0d bid=%0d, want bresp=2 bid=%0d", t, resp_o, id_o, 20 + t);
      end
      model_read(ra[t], rln[t], 2, 1);
      do_read(8'd30, ra[t], rln[t], 2, 1, 0);
      for (int k = 0; k <= rln[t]; k++) begin
        checks++;
        if (rd[k] !== ed[k] || rr[k] !== 2'b00) begin
          errors++; $display("FAIL err_unchanged %0d beat %0d: got data=%h resp=%0d, want data=%h resp=0", t, k, rd[k], rr[k], ed[k]);
        end
      end
    end
    do_read(8'd31, 'h100, 3, 2, 2, 1);
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (rd[k] !== 32'h0 || rr[k] !== 2'b10 || rl[k] !== (k == 3) || ri[k] !== 8'd31) begin
        errors++; $display("FAIL wrap_r beat %0d: got data=%h resp=%0d last=%b id=%0d, want data=0 resp=2 last=%b id=31",
                           k, rd[k], rr[k], rl[k], ri[k], k == 3);
      end
    end
  endtask

  task automatic test_concurrent();
    logic [7:0] id_o; logic [1:0] resp_o, want; int wn;
    for (int it = 0; it < 3; it++) begin
      bd[0] = (it == 0) ? 32'h55 : $urandom; bs[0] = 4'hF;
      model_read('h20, 0, 2, 1);
      fork
        do_write(8'd7, 'h20, 0, 2, 1, 0, 1, -1, id_o, resp_o, wn);
        do_read(8'd8, 'h20, 0, 2, 1, 1);
      join
      want = model_write('h20, 0, 2, 1, 0);
      checks++;
      if (rd[0] !== ed[0] || rr[0] !== 2'b00 || ri[0] !== 8'd8) begin
        errors++; $display("FAIL concurrent_old %0d: got data=%h resp=%0d id=%0d, want data=%h resp=0 id=8", it, rd[0], rr[0], ri[0], ed[0]);
      end
      checks++;
      if (resp_o !== want || id_o !== 8'd7) begin
        errors++; $display("FAIL concurrent_b %0d: got bresp=%0d bid=%0d, want bresp=%0d bid=7", it, resp_o, id_o, want);
      end
      do_read(8'd8, 'h20, 0, 2, 1, 1);
      checks++;
      if (rd[0] !== bd[0]) begin
        errors++; $display("FAIL concurrent_new %0d: got %h, want %h", it, rd[0], bd[0]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit bad;
    for (int k = 0; k < 4; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    aw_send(8'd1, 'h200, 3, 2, 1);
    w_send(bd[0], bs[0], 1'b0, 0);
    w_send(bd[1], bs[1], 1'b0, 0);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b, want 00000", {awready, wready, bvalid, arready, rvalid});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) areset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({awready, wready} !== 2'b10) begin
      errors++; $display("FAIL midreset_idle: got awready/wready %b, want 10", {awready, wready});
    end
    bad = 0;
    repeat (5) begin @(negedge clk); if (bvalid) bad = 1; end
    @(posedge clk); #1;
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_no_b: got bvalid 1, want 0"); end
    void'(model_write('h200, 1, 2, 1, 0));
    model_read('h200, 3, 2, 1);
    do_read(8'd2, 'h200, 3, 2, 1, 0);
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (rd[k] !== ed[k] || rr[k] !== 2'b00) begin
        errors++; $display("FAIL midreset_mem beat %0d: got %h resp=%0d, want %h resp=0", k, rd[k], rr[k], ed[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] id_o, id; logic [1:0] resp_o, want; int wn;
    int addr, len, size, burst, bad;
    for (int it = 0; it < 25; it++) begin
      id    = 8'($urandom);
      len   = $urandom_range(0, 7);
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      burst = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      addr  = ($urandom_range(0, 5) == 0) ? $urandom_range(4060, 4120) : $urandom_range(0, 4095);
      bad   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      for (int k = 0; k <= len; k++) begin bd[k] = $urandom; bs[k] = 4'($urandom); end
      do_write(id, addr, len, size, burst, 1, 1, bad, id_o, resp_o, wn);
      want = model_write(addr, len, size, burst, bad >= 0);
      checks++;
      if (resp_o !== want || id_o !== id) begin
        errors++; $display("FAIL rand_b %0d: got bresp=%0d bid=%0d, want bresp=%0d bid=%0d", it, resp_o, id_o, want, id);
      end
      model_read(addr, len, size, burst);
      do_read(id + 8'd1, addr, len, size, burst, 1);
      for (int k = 0; k <= len; k++) begin
        checks++;
        if (rd[k] !== ed[k] || rr[k] !== er[k] || rl[k] !== (k == len) || ri[k] !== id + 8'd1) begin
          errors++; $display("FAIL rand_r %0d beat %0d: got data=%h resp=%0d last=%b id=%0d, want data=%h resp=%0d last=%b id=%0d",
                             it, k, rd[k], rr[k], rl[k], ri[k], ed[k], er[k], k == len, id + 8'd1);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    fill_memory();
    test_single();
    test_incr_burst();
    test_errors();
    test_concurrent();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
